// File: rtl/cam_pixel_packer_pkg.sv
// Shared types and constants for the camera pixel packer.
// Optional build macro handled by the top: CAM_PIXEL_PACKER_DROPCNT_EN.
package cam_pkg;

  localparam int PIX_PER_WORD = 8;
  localparam int PIX_W        = 16;
  localparam int WORD_W       = 128;
  localparam int LANE_W       = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    WAIT_SOF  = 2'd0,
    PACK      = 2'd1,
    FLUSH     = 2'd2,
    SEND_LAST = 2'd3
  } cam_state_e;

  function automatic int words_per_frame(input int h_active, input int v_active);
    return (h_active * v_active) / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/cam_pixel_packer_if.sv
// AXI-Stream style word bus between the packer and the downstream write FIFO.
interface cam_pixel_packer_if;
  import cam_pkg::*;

  // A word transfers on a clock edge where m_axis_valid and m_axis_ready are
  // both high; data, tlast and valid hold steady until that edge, and valid
  // never depends on ready.
  logic [WORD_W-1:0] m_axis_data;
  logic              m_axis_valid;
  logic              m_axis_tlast;
  logic              m_axis_ready;

  modport master (
    output m_axis_data,
    output m_axis_valid,
    output m_axis_tlast,
    input  m_axis_ready
  );

  modport slave (
    input  m_axis_data,
    input  m_axis_valid,
    input  m_axis_tlast,
    output m_axis_ready
  );

endinterface

// File: rtl/cam_pixel_packer_word_fifo2.sv
// Two-entry word FIFO; a push into a full FIFO is legal only alongside a pop.
module cam_word_fifo2
  import cam_pkg::*;
#(
  parameter int W = WORD_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      if (i_push && !i_pop)      r_count <= r_count + 2'd1;
      else if (!i_push && i_pop) r_count <= r_count - 2'd1;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/cam_pixel_packer.sv
// Packs RGB565 camera pixels eight per 128-bit word onto a stream bus.
// Build macro CAM_PIXEL_PACKER_DROPCNT_EN adds the frames_dropped_out counter.
module cam_pixel_packer
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                pixel_valid_in,
  input  logic [PIX_W-1:0]    pixel_in,
  input  logic [10:0]         hcount_in,
  input  logic [9:0]          vcount_in,
  cam_pixel_packer_if.master  m_axis,
  output logic                overflow_out,
  output logic                resync_out,
`ifdef CAM_PIXEL_PACKER_DROPCNT_EN
  output logic [7:0]          frames_dropped_out,
`endif
  output cam_state_e          dbg_state_out
);

  localparam int WORDS  = words_per_frame(H_ACTIVE, V_ACTIVE);
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(WORDS - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [10:0]       LAST_H    = 11'(H_ACTIVE - 1);
  localparam logic [9:0]        LAST_V    = 10'(V_ACTIVE - 1);

  // Reset asserts immediately and releases two clocks after rst_in rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  cam_state_e          r_state, w_state_nxt;
  logic [LANE_W-1:0]   r_lane, w_lane_nxt;
  logic [WORD_W-1:0]   r_word, w_word_nxt;
  logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
  logic                r_overflow, r_resync;
  logic                w_push, w_push_last, w_resync, w_drop;
  logic [WORD_W-1:0]   w_push_data;
  logic                w_pop, w_full, w_room, w_sof, w_eof;
  logic [WORD_W:0]     w_fifo_out;

  assign w_sof  = pixel_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_eof  = pixel_valid_in && (hcount_in == LAST_H) && (vcount_in == LAST_V);
  assign w_pop  = m_axis.m_axis_valid && m_axis.m_axis_ready;
  assign w_room = !w_full || w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_word_nxt  = r_word;
    w_wcnt_nxt  = r_wcnt;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_push_data = '0;
    w_resync    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      WAIT_SOF: begin
        if (w_sof) begin
          w_word_nxt         = '0;
          w_word_nxt[PIX_W-1:0] = pixel_in;
          w_lane_nxt         = LANE_W'(1);
          w_wcnt_nxt         = '0;
          w_state_nxt        = PACK;
        end
      end
      PACK: begin
        if (w_sof) begin
          w_word_nxt         = '0;
          w_word_nxt[PIX_W-1:0] = pixel_in;
          w_lane_nxt         = LANE_W'(1);
          w_wcnt_nxt         = '0;
          w_resync           = 1'b1;
        end else if (pixel_valid_in) begin
          if (hcount_in[LANE_W-1:0] != r_lane) begin
            w_lane_nxt  = '0;
            w_resync    = 1'b1;
            w_state_nxt = WAIT_SOF;
          end else begin
            w_word_nxt[r_lane*PIX_W +: PIX_W] = pixel_in;
            w_lane_nxt = r_lane + LANE_W'(1);
            if (r_lane == LANE_W'(PIX_PER_WORD - 1)) begin
              w_push_data = w_word_nxt;
              w_push_last = (r_wcnt == LAST_WCNT);
              if (w_room) begin
                w_push     = 1'b1;
                w_wcnt_nxt = w_push_last ? '0 : r_wcnt + WCNT_ONE;
              end else begin
                w_drop      = 1'b1;
                w_state_nxt = FLUSH;
              end
            end
          end
        end
      end
      FLUSH: begin
        // A premature start of frame also ends the flush; that pixel is lost.
        if (w_eof || w_sof) w_state_nxt = SEND_LAST;
      end
      SEND_LAST: begin
        if (w_room) begin
          w_push      = 1'b1;
          w_push_last = 1'b1;
          w_state_nxt = WAIT_SOF;
        end
      end
      default: w_state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= WAIT_SOF;
      r_lane     <= '0;
      r_word     <= '0;
      r_wcnt     <= '0;
      r_overflow <= 1'b0;
      r_resync   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lane     <= w_lane_nxt;
      r_word     <= w_word_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_overflow <= r_overflow | w_drop;
      r_resync   <= w_resync;
    end
  end

  cam_word_fifo2 #(.W(WORD_W + 1)) u_fifo (
    .clk     (clk_in),
    .rst_n   (w_rst_n),
    .i_push  (w_push),
    .i_data  ({w_push_last, w_push_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_valid (m_axis.m_axis_valid),
    .o_full  (w_full)
  );

  assign m_axis.m_axis_data  = w_fifo_out[WORD_W-1:0];
  assign m_axis.m_axis_tlast = w_fifo_out[WORD_W];
  assign overflow_out        = r_overflow;
  assign resync_out          = r_resync;
  assign dbg_state_out       = r_state;

`ifdef CAM_PIXEL_PACKER_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n)                          r_drop_cnt <= 8'd0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end
  assign frames_dropped_out = r_drop_cnt;
`endif

endmodule
